// File: rtl/oled_write_scheduler.sv
// Write scheduler in front of oled_controller: shares its single byte-write port between a
// built-in boot message streamer ("hello") and an external valid/ready byte channel. Holds off
// all writes for DELAY_CYCLES after reset, honours buffer_full and keeps a message atomic.
// Optional feature: define MSG_NEWLINE_EN to append 8'h0A after the message bytes.
module oled_write_scheduler #(
  parameter int unsigned CLK_FREQ     = 20_000_000,
  parameter int unsigned DELAY_CYCLES = CLK_FREQ / 2,
  parameter int unsigned MSG_LEN      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       msg_start,
  output logic       msg_busy,
  input  logic       ext_valid,
  input  logic [7:0] ext_data,
  output logic       ext_ready,
  output logic [7:0] oled_data,
  output logic       oled_we,
  input  logic       oled_full,
  output logic       init_done
);

`ifdef MSG_NEWLINE_EN
  localparam int unsigned NumBytes = MSG_LEN + 1;
`else
  localparam int unsigned NumBytes = MSG_LEN;
`endif
  localparam int unsigned     IdxW      = $clog2(MSG_LEN + 1);
  localparam logic [31:0]     DelayLast = 32'(DELAY_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NumBytes - 1);
  localparam logic [39:0]     Hello     = 40'h68_65_6C_6C_6F;

  typedef enum logic [1:0] {StInitWait, StIdle, StMsg} state_e;

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            pend_q, pend_d;
  logic            last_ext_q, last_ext_d;
  logic            we_q, we_d;
  logic [7:0]      data_q, data_d;
  logic            issue_ok;

  // Positions past the ROM can only be the trailing newline.
  function automatic logic [7:0] msg_byte(input logic [IdxW-1:0] idx);
    int unsigned pos;
    pos = 32'(idx);
    if (pos < MSG_LEN && pos < 5) return Hello[8*(4-pos) +: 8];
    return 8'h0A;
  endfunction

  assign init_done = (state_q != StInitWait);
  assign ext_ready = init_done & ~hold_full_q;
  assign msg_busy  = pend_q | (state_q == StMsg);
  assign oled_we   = we_q;
  assign oled_data = data_q;

  // A strobe last cycle forces a gap so buffer_full can catch up before the next write.
  assign issue_ok = ena & ~oled_full & ~we_q;

  // Next-state: power-up delay, arbitration, message sequencing, hold register, pending latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    pend_d      = pend_q;
    last_ext_d  = last_ext_q;
    we_d        = 1'b0;
    data_d      = data_q;

    unique case (state_q)
      StInitWait: begin
        if (ena) begin
          if (cnt_q == DelayLast) state_d = StIdle;
          else                    cnt_d   = cnt_q + 32'd1;
        end
      end
      StIdle: begin
        if (issue_ok) begin
          // After an external byte a waiting message gets the next turn.
          if (hold_full_q && (!pend_q || !last_ext_q)) begin
            we_d        = 1'b1;
            data_d      = hold_data_q;
            hold_full_d = 1'b0;
            last_ext_d  = 1'b1;
          end else if (pend_q) begin
            state_d    = StMsg;
            idx_d      = '0;
            pend_d     = 1'b0;
            last_ext_d = 1'b0;
          end
        end
      end
      StMsg: begin
        if (issue_ok) begin
          we_d   = 1'b1;
          data_d = msg_byte(idx_q);
          if (idx_q == IdxLast) state_d = StIdle;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = StInitWait;
    endcase

    if (msg_start && !pend_q && state_q != StMsg) pend_d = 1'b1;

    // ext_ready implies the hold register is empty, so this never collides with an issue.
    if (ext_valid && ext_ready) begin
      hold_full_d = 1'b1;
      hold_data_d = ext_data;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInitWait;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      pend_q      <= 1'b0;
      last_ext_q  <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      pend_q      <= pend_d;
      last_ext_q  <= last_ext_d;
      we_q        <= we_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_oled_write_scheduler.sv
// Self-checking bench for oled_write_scheduler: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based reference model of the scheduling rules.
module tb_oled_write_scheduler;

  localparam int Delay = 10;
`ifdef MSG_NEWLINE_EN
  localparam int NBytes = 6;
`else
  localparam int NBytes = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       msg_start = 1'b0;
  logic       ext_valid = 1'b0;
  logic [7:0] ext_data = 8'h00;
  logic       oled_full = 1'b0;
  logic       msg_busy, ext_ready, oled_we, init_done;
  logic [7:0] oled_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_write_scheduler #(.DELAY_CYCLES(Delay)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .msg_start (msg_start),
    .msg_busy  (msg_busy),
    .ext_valid (ext_valid),
    .ext_data  (ext_data),
    .ext_ready (ext_ready),
    .oled_data (oled_data),
    .oled_we   (oled_we),
    .oled_full (oled_full),
    .init_done (init_done)
  );

  function automatic logic [7:0] exp_byte(input int i);
    case (i)
      0:       return 8'h68;
      1:       return 8'h65;
      2, 3:    return 8'h6C;
      4:       return 8'h6F;
      default: return 8'h0A;
    endcase
  endfunction

  // Reference model: delay count, pending request, message position, queue of held bytes.
  bit         m_init = 0, m_pend = 0, m_in_msg = 0, m_last_ext = 0, exp_we = 0;
  int         m_cnt = 0, m_idx = 0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] held[$];

  initial forever begin
    bit o_init, o_pend, o_in, issue;
    int o_held;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_init = 0; m_pend = 0; m_in_msg = 0; m_last_ext = 0; exp_we = 0;
      m_cnt = 0; m_idx = 0; exp_data = 8'h00; held.delete();
    end else begin
      o_init = m_init; o_pend = m_pend; o_in = m_in_msg; o_held = held.size();
      issue = ena && !oled_full && !exp_we;
      exp_we = 0;
      if (!o_init) begin
        if (ena) begin
          if (m_cnt == Delay - 1) m_init = 1;
          else m_cnt++;
        end
      end else if (o_in) begin
        if (issue) begin
          exp_we = 1; exp_data = exp_byte(m_idx); m_idx++;
          if (m_idx == NBytes) m_in_msg = 0;
        end
      end else if (issue) begin
        if (o_held > 0 && (!o_pend || !m_last_ext)) begin
          exp_we = 1; exp_data = held.pop_front(); m_last_ext = 1;
        end else if (o_pend) begin
          m_in_msg = 1; m_idx = 0; m_pend = 0; m_last_ext = 0;
        end
      end
      if (msg_start && !o_pend && !o_in) m_pend = 1;
      if (ext_valid && o_init && o_held == 0) held.push_back(ext_data);
    end
  end

  // Strobe log with the cycle each strobe was seen.
  logic [7:0] seen[$];
  int         seen_cyc[$];
  int         cyc = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (oled_we === 1'b1) begin
      seen.push_back(oled_data);
      seen_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_strobe(input logic [7:0] b, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (oled_we === 1'b1 && oled_data === b) ok = 1;
    end
  endtask

  task automatic pulse_start();
    msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({oled_we, oled_data, init_done, ext_ready, msg_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b data=%h init=%b ready=%b busy=%b, required all 0",
               oled_we, oled_data, init_done, ext_ready, msg_busy);
    end
  endtask

  task automatic test_boot_msg();
    int first_init = -1;
    seen.delete(); seen_cyc.delete();
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      msg_start = (k == 2);
      if (init_done === 1'b1 && first_init < 0) first_init = k;
      checks++;
      if (oled_we === 1'b1 && init_done !== 1'b1) begin
        errors++;
        $display("FAIL write_before_init: we=1 with init_done=%b at cycle %0d", init_done, k);
      end
      if (k == 3) begin
        checks++;
        if (msg_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_during_init: got %b, required 1", msg_busy);
        end
      end
    end
    checks++;
    if (first_init != Delay) begin
      errors++;
      $display("FAIL init_delay: init_done after %0d cycles, required %0d", first_init, Delay);
    end
    checks++;
    if (seen.size() != NBytes) begin
      errors++;
      $display("FAIL boot_count: got %0d strobes, required %0d", seen.size(), NBytes);
    end else begin
      for (int i = 0; i < NBytes; i++) begin
        checks++;
        if (seen[i] !== exp_byte(i)) begin
          errors++;
          $display("FAIL boot_byte%0d: got %h, required %h", i, seen[i], exp_byte(i));
        end
        if (i > 0) begin
          checks++;
          if (seen_cyc[i] - seen_cyc[i-1] != 2) begin
            errors++;
            $display("FAIL boot_gap%0d: got %0d cycles, required 2", i,
                     seen_cyc[i] - seen_cyc[i-1]);
          end
        end
      end
    end
    checks++;
    if (msg_busy !== 1'b0) begin
      errors++;
      $display("FAIL boot_busy_end: got %b, required 0", msg_busy);
    end
  endtask

  task automatic test_ext_single();
    repeat (2) @(negedge clk);
    checks++;
    if (ext_ready !== 1'b1) begin
      errors++;
      $display("FAIL ext_ready_idle: got %b, required 1", ext_ready);
    end
    seen.delete(); seen_cyc.delete();
    ext_valid = 1'b1; ext_data = 8'h41;
    @(negedge clk);
    ext_valid = 1'b0;
    checks++;
    if ({ext_ready, oled_we} !== 2'b00) begin
      errors++;
      $display("FAIL ext_ready_drop: got ready=%b we=%b, required 0 0", ext_ready, oled_we);
    end
    @(negedge clk);
    checks++;
    if ({ext_ready, oled_we, oled_data} !== {1'b1, 1'b1, 8'h41}) begin
      errors++;
      $display("FAIL ext_strobe: got ready=%b we=%b data=%h, required 1 1 41",
               ext_ready, oled_we, oled_data);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (seen.size() != 1) begin
      errors++;
      $display("FAIL ext_single_count: got %0d strobes, required 1", seen.size());
    end
  endtask

  task automatic test_ext_priority();
    bit ok;
    logic [7:0] exp_q[$];
    seen.delete(); seen_cyc.delete();
    pulse_start();
    wait_strobe(8'h68, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL prio_first_byte: got no 68 strobe, required one"); end
    ext_valid = 1'b1; ext_data = 8'h41;
    @(negedge clk);
    ext_valid = 1'b0;
    checks++;
    if (ext_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold_full: got ready=%b, required 0", ext_ready);
    end
    wait_strobe(exp_byte(NBytes - 1), 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL prio_last_byte: got no final strobe, required one"); end
    pulse_start();
    repeat (30) @(negedge clk);
    for (int i = 0; i < NBytes; i++) exp_q.push_back(exp_byte(i));
    exp_q.push_back(8'h41);
    for (int i = 0; i < NBytes; i++) exp_q.push_back(exp_byte(i));
    checks++;
    if (seen.size() != exp_q.size()) begin
      errors++;
      $display("FAIL prio_count: got %0d strobes, required %0d", seen.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (seen[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL prio_byte%0d: got %h, required %h", i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    bit ok;
    seen.delete(); seen_cyc.delete();
    pulse_start();
    wait_strobe(8'h65, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_second_byte: got no 65 strobe, required one"); end
    oled_full = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (oled_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_strobe: got we=%b in full cycle %0d, required 0", oled_we, i);
      end
    end
    oled_full = 1'b0;
    @(negedge clk);
    checks++;
    if ({oled_we, oled_data} !== {1'b1, 8'h6C}) begin
      errors++;
      $display("FAIL stall_resume: got we=%b data=%h, required 1 6C", oled_we, oled_data);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (seen.size() != NBytes) begin
      errors++;
      $display("FAIL stall_count: got %0d strobes, required %0d", seen.size(), NBytes);
    end else begin
      for (int i = 0; i < NBytes; i++) begin
        checks++;
        if (seen[i] !== exp_byte(i)) begin
          errors++;
          $display("FAIL stall_byte%0d: got %h, required %h", i, seen[i], exp_byte(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first_init = -1;
    pulse_start();
    wait_strobe(8'h6C, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_third_byte: got no 6C strobe, required one"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({oled_we, oled_data, init_done, ext_ready, msg_busy} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_async: got we=%b data=%h init=%b ready=%b busy=%b, required all 0",
               oled_we, oled_data, init_done, ext_ready, msg_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen.delete(); seen_cyc.delete();
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (init_done === 1'b1 && first_init < 0) first_init = k;
    end
    checks++;
    if (first_init != Delay) begin
      errors++;
      $display("FAIL rstmid_delay: init_done after %0d cycles, required %0d", first_init, Delay);
    end
    checks++;
    if (seen.size() != 0 || msg_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got %0d strobes busy=%b, required 0 strobes busy=0",
               seen.size(), msg_busy);
    end
  endtask

  task automatic test_random();
    logic [11:0] got, want;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      got  = {oled_we, oled_data, init_done, ext_ready, msg_busy};
      want = {exp_we, exp_data, m_init, m_init && held.size() == 0, m_pend || m_in_msg};
      checks++;
      if (got !== want) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_cycle%0d: got we,data,init,ready,busy=%h, required %h",
                   c, got, want);
      end
      rst_n     = !(c >= 1500 && c < 1503);
      ena       = ($urandom_range(0, 9) != 0);
      oled_full = ($urandom_range(0, 4) == 0);
      msg_start = ($urandom_range(0, 19) == 0);
      ext_valid = ($urandom_range(0, 2) == 0);
      ext_data  = 8'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_boot_msg();
    test_ext_single();
    test_ext_priority();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
